// File: rtl/irq_controller.sv
// Prioritised interrupt controller: synchronises and edge-captures peripheral lines,
// raises irq with a latched handler vector and waits for the CPU ack and a software EOI.
module irq_controller #(
   parameter int unsigned NUM_SOURCES       = 8,
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned VEC_SHIFT         = 2,
   parameter logic [15:0] RESET_VECTOR_BASE = 16'hFF00
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_SOURCES-1:0] irq_src,
   input  logic                   mmio_write,
   input  logic [1:0]             mmio_addr,
   input  logic [15:0]            mmio_wdata,
   output logic [15:0]            mmio_rdata,
   output logic                   irq,
   output logic [15:0]            irq_vector,
   input  logic                   reset_irq,
   output logic [3:0]             irq_active_id
);

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StAssert    = 2'd1,
      StInService = 2'd2
   } state_e;

   logic [NUM_SOURCES-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SOURCES-1:0] edge_q;
   logic [NUM_SOURCES-1:0] rise;
   logic [NUM_SOURCES-1:0] pending_q, pending_d;
   logic [NUM_SOURCES-1:0] mask_q;
   logic [NUM_SOURCES-1:0] req;
   logic [NUM_SOURCES-1:0] w1c_bits;
   logic [NUM_SOURCES-1:0] ack_bits;
   logic                   enable_q;
   logic [15:0]            base_q;
   state_e                 state_q;
   logic                   irq_q;
   logic [15:0]            vector_q;
   logic [3:0]             id_q;
   logic [3:0]             lowest;
   logic                   wr_pending, wr_mask, wr_base, wr_ctrl;
   logic                   eoi;

   // Synchroniser chain plus one extra flop for rising-edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         edge_q <= '0;
      end else begin
         sync_q[0] <= irq_src;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

   assign wr_pending = mmio_write && (mmio_addr == 2'd0);
   assign wr_mask    = mmio_write && (mmio_addr == 2'd1);
   assign wr_base    = mmio_write && (mmio_addr == 2'd2);
   assign wr_ctrl    = mmio_write && (mmio_addr == 2'd3);
   assign eoi        = wr_ctrl && mmio_wdata[1];

   assign req      = pending_q & mask_q;
   assign w1c_bits = wr_pending ? mmio_wdata[NUM_SOURCES-1:0] : '0;
   assign ack_bits = (state_q == StAssert && reset_irq) ? (NUM_SOURCES'(1) << id_q) : '0;

   // New edges are ORed in last so they win over W1C and ack clears
   assign pending_d = (pending_q & ~w1c_bits & ~ack_bits) | rise;

   // Lowest-index requesting source has priority
   always_comb begin
      lowest = 4'd0;
      for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
         if (req[i]) lowest = 4'(i);
      end
   end

   // Software-visible registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         mask_q    <= '0;
         enable_q  <= 1'b0;
         base_q    <= RESET_VECTOR_BASE;
      end else begin
         pending_q <= pending_d;
         if (wr_mask) mask_q   <= mmio_wdata[NUM_SOURCES-1:0];
         if (wr_base) base_q   <= mmio_wdata;
         if (wr_ctrl) enable_q <= mmio_wdata[0];
      end
   end

   // Request FSM; id and vector are latched on entry to StAssert and frozen afterwards
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         irq_q    <= 1'b0;
         vector_q <= RESET_VECTOR_BASE;
         id_q     <= 4'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (enable_q && |req) begin
                  state_q  <= StAssert;
                  irq_q    <= 1'b1;
                  id_q     <= lowest;
                  vector_q <= base_q + (16'(lowest) << VEC_SHIFT);
               end
            end
            StAssert: begin
               if (reset_irq) begin
                  state_q <= StInService;
                  irq_q   <= 1'b0;
               end
            end
            StInService: begin
               if (eoi) state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign irq           = irq_q;
   assign irq_vector    = vector_q;
   assign irq_active_id = id_q;

   // Combinational register read-back
   always_comb begin
      mmio_rdata = 16'h0000;
      unique case (mmio_addr)
         2'd0: mmio_rdata = 16'(pending_q);
         2'd1: mmio_rdata = 16'(mask_q);
         2'd2: mmio_rdata = base_q;
         2'd3: mmio_rdata = {state_q, 6'b0, id_q, 3'b0, enable_q};
         default: mmio_rdata = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed stimulus, a behavioural model
// compared every cycle, and literal spot checks.
module tb_irq_controller;

   localparam int N    = 8;
   localparam int SYNC = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  irq_src = '0;
   logic          mmio_write = 1'b0;
   logic [1:0]    mmio_addr = 2'd0;
   logic [15:0]   mmio_wdata = 16'h0000;
   logic [15:0]   mmio_rdata;
   logic          irq;
   logic [15:0]   irq_vector;
   logic          reset_irq = 1'b0;
   logic [3:0]    irq_active_id;

   int n_cmp = 0;
   int n_bad = 0;

   irq_controller #(
      .NUM_SOURCES      (N),
      .SYNC_STAGES      (SYNC),
      .VEC_SHIFT        (2),
      .RESET_VECTOR_BASE(16'hFF00)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .irq_src      (irq_src),
      .mmio_write   (mmio_write),
      .mmio_addr    (mmio_addr),
      .mmio_wdata   (mmio_wdata),
      .mmio_rdata   (mmio_rdata),
      .irq          (irq),
      .irq_vector   (irq_vector),
      .reset_irq    (reset_irq),
      .irq_active_id(irq_active_id)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // hist[k] holds irq_src as sampled k+1 posedges ago; an edge becomes pending
   // SYNC posedges after the sample that first saw it high.
   logic [N-1:0] hist [SYNC+1];
   logic [N-1:0] m_pending, m_mask;
   logic         m_enable;
   logic [15:0]  m_base, m_vec;
   logic [1:0]   m_state;
   logic [3:0]   m_id;
   logic [N-1:0] m_rise, m_w1c, m_ack;

   function automatic logic [3:0] lowest_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return 4'(i);
      return 4'd0;
   endfunction

   function automatic logic [15:0] exp_rdata(input logic [1:0] a);
      case (a)
         2'd0:    return 16'(m_pending);
         2'd1:    return 16'(m_mask);
         2'd2:    return m_base;
         default: return {m_state, 6'b0, m_id, 3'b0, m_enable};
      endcase
   endfunction

   assign m_rise = hist[SYNC-1] & ~hist[SYNC];
   assign m_w1c  = (mmio_write && mmio_addr == 2'd0) ? mmio_wdata[N-1:0] : '0;
   assign m_ack  = (m_state == 2'd1 && reset_irq) ? (N'(1) << m_id) : '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i <= SYNC; i++) hist[i] <= '0;
         m_pending <= '0;
         m_mask    <= '0;
         m_enable  <= 1'b0;
         m_base    <= 16'hFF00;
         m_vec     <= 16'hFF00;
         m_state   <= 2'd0;
         m_id      <= 4'd0;
      end else begin
         hist[0] <= irq_src;
         for (int i = 1; i <= SYNC; i++) hist[i] <= hist[i-1];
         m_pending <= (m_pending & ~m_w1c & ~m_ack) | m_rise;
         if (mmio_write) begin
            case (mmio_addr)
               2'd1:    m_mask   <= mmio_wdata[N-1:0];
               2'd2:    m_base   <= mmio_wdata;
               2'd3:    m_enable <= mmio_wdata[0];
               default: ;
            endcase
         end
         case (m_state)
            2'd0: if (m_enable && (m_pending & m_mask) != '0) begin
               m_state <= 2'd1;
               m_id    <= lowest_of(m_pending & m_mask);
               m_vec   <= m_base + 16'(lowest_of(m_pending & m_mask)) * 16'd4;
            end
            2'd1: if (reset_irq) m_state <= 2'd2;
            2'd2: if (mmio_write && mmio_addr == 2'd3 && mmio_wdata[1]) m_state <= 2'd0;
            default: m_state <= 2'd0;
         endcase
      end
   end

   // Compare every cycle on the inactive edge
   always @(negedge clock) begin
      check("model irq", 16'(irq), 16'(m_state == 2'd1));
      check("model irq_vector", irq_vector, m_vec);
      check("model irq_active_id", 16'(irq_active_id), 16'(m_id));
      check("model mmio_rdata", mmio_rdata, exp_rdata(mmio_addr));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      mmio_write = 1'b1;
      mmio_addr  = a;
      mmio_wdata = d;
      tick();
      mmio_write = 1'b0;
   endtask

   task automatic rd_check(input logic [1:0] a, input logic [15:0] e, input string name);
      mmio_addr = a;
      #1;
      check(name, mmio_rdata, e);
   endtask

   task automatic pulse(input logic [N-1:0] m);
      irq_src = m;
      tick();
      irq_src = '0;
   endtask

   task automatic ack();
      reset_irq = 1'b1;
      tick();
      reset_irq = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check("reset irq", 16'(irq), 16'h0000);
      check("reset vector", irq_vector, 16'hFF00);
      reset = 1'b1;
      tick();
      rd_check(2'd0, 16'h0000, "reset PENDING");
      rd_check(2'd1, 16'h0000, "reset MASK");
      rd_check(2'd2, 16'hFF00, "reset VECTOR_BASE");
      rd_check(2'd3, 16'h0000, "reset CTRL");

      // Single source
      tick();
      wr(2'd1, 16'h0001);
      wr(2'd2, 16'h8000);
      wr(2'd3, 16'h0001);
      pulse(8'h01);                       // posedge 1
      tick();                             // posedge 2
      tick();                             // posedge 3
      check("single irq@3", 16'(irq), 16'h0000);
      rd_check(2'd0, 16'h0001, "single PENDING@3");
      tick();                             // posedge 4
      check("single irq@4", 16'(irq), 16'h0001);
      check("single vector", irq_vector, 16'h8000);
      check("single id", 16'(irq_active_id), 16'h0000);
      rd_check(2'd3, 16'h4001, "single CTRL assert");
      ack();
      check("single irq after ack", 16'(irq), 16'h0000);
      rd_check(2'd0, 16'h0000, "single PENDING after ack");
      rd_check(2'd3, 16'h8001, "single CTRL in service");
      wr(2'd3, 16'h0003);
      rd_check(2'd3, 16'h0001, "single CTRL idle after EOI");

      // Priority: sources 5 and 2 together
      wr(2'd1, 16'h00FF);
      pulse(8'h24);
      repeat (3) tick();
      check("prio irq", 16'(irq), 16'h0001);
      check("prio vector id2", irq_vector, 16'h8008);
      check("prio id2", 16'(irq_active_id), 16'h0002);
      rd_check(2'd3, 16'h4021, "prio CTRL");
      ack();
      rd_check(2'd0, 16'h0020, "prio PENDING after ack");
      wr(2'd3, 16'h0003);
      check("prio irq at EOI edge", 16'(irq), 16'h0000);
      tick();
      check("prio reassert", 16'(irq), 16'h0001);
      check("prio vector id5", irq_vector, 16'h8014);
      check("prio id5", 16'(irq_active_id), 16'h0005);
      ack();
      wr(2'd3, 16'h0003);

      // Holdoff while in service
      pulse(8'h01);
      repeat (3) tick();
      ack();
      pulse(8'h08);
      repeat (4) tick();
      rd_check(2'd0, 16'h0008, "holdoff PENDING");
      check("holdoff irq low", 16'(irq), 16'h0000);
      wr(2'd3, 16'h0003);
      check("holdoff irq at EOI edge", 16'(irq), 16'h0000);
      tick();
      check("holdoff irq after EOI", 16'(irq), 16'h0001);
      check("holdoff vector", irq_vector, 16'h800C);
      ack();
      wr(2'd3, 16'h0003);

      // Masked source
      wr(2'd1, 16'h00FD);
      pulse(8'h02);
      repeat (4) tick();
      rd_check(2'd0, 16'h0002, "mask PENDING");
      check("mask irq low", 16'(irq), 16'h0000);
      wr(2'd0, 16'h0002);
      rd_check(2'd0, 16'h0000, "mask W1C");

      // Commit: writes during ASSERT do not abort
      wr(2'd1, 16'h00FF);
      pulse(8'h80);
      repeat (3) tick();
      check("commit irq", 16'(irq), 16'h0001);
      wr(2'd1, 16'h0000);
      wr(2'd2, 16'h1234);
      wr(2'd3, 16'h0003);
      check("commit irq held", 16'(irq), 16'h0001);
      check("commit vector frozen", irq_vector, 16'h801C);
      check("commit id frozen", 16'(irq_active_id), 16'h0007);
      ack();
      check("commit irq after ack", 16'(irq), 16'h0000);
      wr(2'd3, 16'h0003);
      wr(2'd1, 16'h00FF);
      wr(2'd2, 16'h8000);

      // W1C collides with a fresh edge on bit 4
      wr(2'd3, 16'h0000);
      pulse(8'h10);
      repeat (3) tick();
      rd_check(2'd0, 16'h0010, "collide PENDING before");
      irq_src = 8'h10;
      tick();
      tick();
      wr(2'd0, 16'h0010);
      rd_check(2'd0, 16'h0010, "collide edge wins");
      irq_src = 8'h00;
      repeat (3) tick();
      wr(2'd0, 16'h0010);
      rd_check(2'd0, 16'h0000, "collide plain W1C");

      // Held-high line pends exactly once
      wr(2'd3, 16'h0001);
      irq_src = 8'h40;
      repeat (4) tick();
      check("held irq", 16'(irq), 16'h0001);
      check("held id", 16'(irq_active_id), 16'h0006);
      ack();
      repeat (6) tick();
      rd_check(2'd0, 16'h0000, "held no repend");
      wr(2'd3, 16'h0003);
      repeat (3) tick();
      check("held irq stays low", 16'(irq), 16'h0000);
      irq_src = 8'h00;

      // Reset in the middle of ASSERT
      repeat (3) tick();
      pulse(8'h01);
      repeat (3) tick();
      check("midreset irq before", 16'(irq), 16'h0001);
      reset = 1'b0;
      #1;
      check("midreset irq", 16'(irq), 16'h0000);
      check("midreset vector", irq_vector, 16'hFF00);
      check("midreset id", 16'(irq_active_id), 16'h0000);
      rd_check(2'd0, 16'h0000, "midreset PENDING");
      rd_check(2'd1, 16'h0000, "midreset MASK");
      rd_check(2'd2, 16'hFF00, "midreset VECTOR_BASE");
      rd_check(2'd3, 16'h0000, "midreset CTRL");
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check("post reset irq", 16'(irq), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
